regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register pending-write scoreboard and optional write-to-read bypass. It sits between decode/issue and writeback in the datapath. It generalises the single-write, two-read, 64x32 register file to N read ports, M write ports, configurable width and depth, and hazard tracking. Issue uses the scoreboard to stall on RAW hazards; writeback ports retire results and clear the pending bits.

---
 rtl/regfile_mp.sv | 90 +++++++++
 tb/tb_regfile_mp.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: N-read / M-write register file with pending-write scoreboard.
// Optional same-cycle write-to-read forwarding and hardwired zero register.
module regfile_mp #(
   parameter int DATA_W   = 64,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_RD*AW-1:0]     rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*AW-1:0]     wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic                     iss_en_i,
   input  logic [AW-1:0]            iss_addr_i,
   output logic [NUM_REGS-1:0]      busy_o
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   logic [NUM_REGS-1:0]             busy_q;
   logic [NUM_REGS-1:0]             busy_d;
   logic [NUM_REGS-1:0]             set_v;
   logic [NUM_REGS-1:0]             clr_v;

   // decode issue (set) and writeback (clear) per register; set wins
   always_comb begin
      set_v = '0;
      clr_v = '0;
      if (iss_en_i) set_v[iss_addr_i] = 1'b1;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_en_i[k]) clr_v[wr_addr_i[k*AW +: AW]] = 1'b1;
      end
      busy_d = (busy_q & ~clr_v) | set_v;
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   // scoreboard state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= busy_d;
   end

   // storage; later (higher) ports overwrite earlier ones on collision
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en_i[k] &&
                !(ZERO_REG != 0 && wr_addr_i[k*AW +: AW] == '0))
               regs_q[wr_addr_i[k*AW +: AW]] <=
                  wr_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   // read muxes with optional forwarding from this cycle's writes
   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         logic [AW-1:0]     a;
         logic [DATA_W-1:0] d;
         a = rd_addr_i[j*AW +: AW];
         d = regs_q[a];
         if (BYPASS != 0) begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (wr_en_i[k] && wr_addr_i[k*AW +: AW] == a)
                  d = wr_data_i[k*DATA_W +: DATA_W];
            end
         end
         if (ZERO_REG != 0 && a == '0) d = '0;
         rd_data_o[j*DATA_W +: DATA_W] = d;
         rd_busy_o[j] = busy_q[a] && !(BYPASS != 0 && clr_v[a]);
      end
      if (!reset_n) begin
         rd_data_o = '0;
         rd_busy_o = '0;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on bypass/no-bypass instances plus a
// randomised run of a 3R/3W 16x32 instance against an array model.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [9:0]   rd_addr;
   logic [1:0]   wr_en;
   logic [9:0]   wr_addr;
   logic [127:0] wr_data;
   logic         iss_en;
   logic [4:0]   iss_addr;
   logic [127:0] a_rd_data, b_rd_data;
   logic [1:0]   a_rd_busy, b_rd_busy;
   logic [31:0]  a_busy, b_busy;

   logic [11:0]  r_rd_addr;
   logic [2:0]   r_wr_en;
   logic [11:0]  r_wr_addr;
   logic [95:0]  r_wr_data;
   logic         r_iss_en;
   logic [3:0]   r_iss_addr;
   logic [95:0]  r_rd_data;
   logic [2:0]   r_rd_busy;
   logic [15:0]  r_busy;

   logic [31:0]  m_mem [16];
   bit           m_sb  [16];
   bit           n_sb  [16];
   logic [3:0]   sa;
   logic [31:0]  se;
   bit           shit;
   bit           sset;
   bit           sclr;
   logic [15:0]  sbv;

   regfile_mp #(
      .DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
      .BYPASS(1), .ZERO_REG(1)
   ) u_a (
      .clk(clk), .reset_n(reset_n),
      .rd_addr_i(rd_addr), .rd_data_o(a_rd_data), .rd_busy_o(a_rd_busy),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_o(a_busy)
   );

   regfile_mp #(
      .DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
      .BYPASS(0), .ZERO_REG(1)
   ) u_b (
      .clk(clk), .reset_n(reset_n),
      .rd_addr_i(rd_addr), .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_o(b_busy)
   );

   regfile_mp #(
      .DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(3),
      .BYPASS(1), .ZERO_REG(0)
   ) u_r (
      .clk(clk), .reset_n(reset_n),
      .rd_addr_i(r_rd_addr), .rd_data_o(r_rd_data), .rd_busy_o(r_rd_busy),
      .wr_en_i(r_wr_en), .wr_addr_i(r_wr_addr), .wr_data_i(r_wr_data),
      .iss_en_i(r_iss_en), .iss_addr_i(r_iss_addr), .busy_o(r_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wr_en  = '0;
      iss_en = 1'b0;
   endtask

   task automatic rd2(input logic [4:0] x, input logic [4:0] y);
      rd_addr = {y, x};
   endtask

   task automatic wr(input int p, input logic [4:0] ad,
                     input logic [63:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*5 +: 5]   = ad;
      wr_data[p*64 +: 64] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;
      r_rd_addr = '0; r_wr_en = '0; r_wr_addr = '0; r_wr_data = '0;
      r_iss_en = 1'b0; r_iss_addr = '0;
      reset_n = 1'b0;
      repeat (2) step();

      for (int i = 0; i < 32; i++) begin
         rd2(5'(i), 5'(i));
         #1;
         chk("rst_a_d0", a_rd_data[63:0], 64'd0);
         chk("rst_a_d1", a_rd_data[127:64], 64'd0);
         chk("rst_b_d0", b_rd_data[63:0], 64'd0);
         chk("rst_b_d1", b_rd_data[127:64], 64'd0);
         chk("rst_rdbusy", {62'd0, a_rd_busy | b_rd_busy}, 64'd0);
      end
      chk("rst_busy_a", {32'd0, a_busy}, 64'd0);
      chk("rst_busy_b", {32'd0, b_busy}, 64'd0);
      chk("rst_busy_r", {48'd0, r_busy}, 64'd0);

      wr(0, 5'd5, 64'hDEAD);
      rd2(5'd5, 5'd5);
      #1;
      chk("rst_byp_a", a_rd_data[63:0], 64'd0);
      chk("rst_byp_b", b_rd_data[63:0], 64'd0);
      idle();
      reset_n = 1'b1;
      step();

      wr(0, 5'd5, 64'hDEAD);
      step();
      idle();
      rd2(5'd5, 5'd5);
      #1;
      chk("x5_a", a_rd_data[63:0], 64'hDEAD);
      chk("x5_b", b_rd_data[63:0], 64'hDEAD);
      reset_n = 1'b0;
      #1;
      chk("x5_rst_a", a_rd_data[63:0], 64'd0);
      chk("x5_rst_b", b_rd_data[63:0], 64'd0);
      #1;
      reset_n = 1'b1;
      step();

      wr(0, 5'd3, 64'h1234_5678);
      rd2(5'd3, 5'd3);
      #1;
      chk("x3_byp_p0", a_rd_data[63:0], 64'h1234_5678);
      chk("x3_byp_p1", a_rd_data[127:64], 64'h1234_5678);
      chk("x3_nob_p0", b_rd_data[63:0], 64'd0);
      chk("x3_nob_p1", b_rd_data[127:64], 64'd0);
      step();
      idle();
      #1;
      chk("x3_nob_next", b_rd_data[63:0], 64'h1234_5678);

      wr(0, 5'd7, 64'hAAAA);
      wr(1, 5'd7, 64'hBBBB);
      rd2(5'd7, 5'd7);
      #1;
      chk("x7_byp_p0", a_rd_data[63:0], 64'hBBBB);
      chk("x7_byp_p1", a_rd_data[127:64], 64'hBBBB);
      chk("x7_nob_old", b_rd_data[63:0], 64'd0);
      step();
      idle();
      #1;
      chk("x7_a", a_rd_data[63:0], 64'hBBBB);
      chk("x7_b", b_rd_data[127:64], 64'hBBBB);

      wr(0, 5'd0, 64'hFFFF);
      rd2(5'd0, 5'd0);
      #1;
      chk("x0_byp_a", a_rd_data[63:0], 64'd0);
      chk("x0_byp_b", b_rd_data[63:0], 64'd0);
      step();
      idle();
      #1;
      chk("x0_a", a_rd_data[63:0], 64'd0);
      chk("x0_b", b_rd_data[127:64], 64'd0);
      iss_en = 1'b1;
      iss_addr = 5'd0;
      step();
      idle();
      #1;
      chk("x0_busy_a", {63'd0, a_busy[0]}, 64'd0);
      chk("x0_busy_b", {63'd0, b_busy[0]}, 64'd0);

      iss_en = 1'b1;
      iss_addr = 5'd9;
      step();
      idle();
      rd2(5'd9, 5'd9);
      #1;
      chk("x9_rdbusy_a", {62'd0, a_rd_busy}, 64'd3);
      chk("x9_rdbusy_b", {62'd0, b_rd_busy}, 64'd3);
      chk("x9_busy_a", {63'd0, a_busy[9]}, 64'd1);
      chk("x9_busy_b", {63'd0, b_busy[9]}, 64'd1);
      wr(1, 5'd9, 64'h42);
      #1;
      chk("x9_wb_rdbusy_a", {62'd0, a_rd_busy}, 64'd0);
      chk("x9_wb_data_a", a_rd_data[63:0], 64'h42);
      chk("x9_wb_rdbusy_b", {62'd0, b_rd_busy}, 64'd3);
      chk("x9_wb_data_b", b_rd_data[63:0], 64'd0);
      step();
      idle();
      #1;
      chk("x9_clr_a", {63'd0, a_busy[9]}, 64'd0);
      chk("x9_clr_b", {63'd0, b_busy[9]}, 64'd0);
      chk("x9_clr_rdbusy_b", {62'd0, b_rd_busy}, 64'd0);
      chk("x9_data_b", b_rd_data[63:0], 64'h42);

      iss_en = 1'b1;
      iss_addr = 5'd4;
      wr(0, 5'd4, 64'h10);
      step();
      idle();
      rd2(5'd4, 5'd4);
      #1;
      chk("x4_busy_a", {63'd0, a_busy[4]}, 64'd1);
      chk("x4_busy_b", {63'd0, b_busy[4]}, 64'd1);
      chk("x4_data_a", a_rd_data[63:0], 64'h10);
      chk("x4_data_b", b_rd_data[63:0], 64'h10);
      chk("x4_rdbusy_a", {62'd0, a_rd_busy}, 64'd3);
      iss_en = 1'b1;
      iss_addr = 5'd4;
      step();
      idle();
      #1;
      chk("x4_waw_a", {63'd0, a_busy[4]}, 64'd1);
      wr(1, 5'd4, 64'h20);
      step();
      idle();
      #1;
      chk("x4_waw_clr_a", {63'd0, a_busy[4]}, 64'd0);
      chk("x4_waw_data_b", b_rd_data[63:0], 64'h20);

      for (int i = 0; i < 16; i++) begin
         m_mem[i] = '0;
         m_sb[i]  = 1'b0;
      end
      for (int c = 0; c < 10000; c++) begin
         r_rd_addr  = 12'($urandom());
         r_wr_en    = 3'($urandom());
         r_wr_addr  = 12'($urandom());
         r_wr_data  = {$urandom(), $urandom(), $urandom()};
         r_iss_en   = 1'($urandom_range(0, 1));
         r_iss_addr = 4'($urandom());
         #1;
         for (int j = 0; j < 3; j++) begin
            sa = r_rd_addr[j*4 +: 4];
            se = m_mem[sa];
            shit = 1'b0;
            for (int k = 0; k < 3; k++) begin
               if (r_wr_en[k] && r_wr_addr[k*4 +: 4] == sa) begin
                  se = r_wr_data[k*32 +: 32];
                  shit = 1'b1;
               end
            end
            chk("sw_data", {32'd0, r_rd_data[j*32 +: 32]}, {32'd0, se});
            chk("sw_rdbusy", {63'd0, r_rd_busy[j]},
                {63'd0, m_sb[sa] && !shit});
         end
         for (int i = 0; i < 16; i++) sbv[i] = m_sb[i];
         chk("sw_busy", {48'd0, r_busy}, {48'd0, sbv});
         for (int i = 0; i < 16; i++) begin
            sset = r_iss_en && (r_iss_addr == 4'(i));
            sclr = 1'b0;
            for (int k = 0; k < 3; k++)
               if (r_wr_en[k] && r_wr_addr[k*4 +: 4] == 4'(i)) sclr = 1'b1;
            n_sb[i] = sset ? 1'b1 : (sclr ? 1'b0 : m_sb[i]);
         end
         for (int i = 0; i < 16; i++) m_sb[i] = n_sb[i];
         for (int k = 0; k < 3; k++)
            if (r_wr_en[k])
               m_mem[r_wr_addr[k*4 +: 4]] = r_wr_data[k*32 +: 32];
         step();
      end
      r_wr_en  = '0;
      r_iss_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
